// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and parity helper for the UART receive path
package uart_pkg;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Receiver FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Flag positions above the data field in a FIFO entry: {BE, PE, FE, data}
  localparam int FLAG_FE = 0;
  localparam int FLAG_PE = 1;
  localparam int FLAG_BE = 2;

  // Expected parity bit for up to 9 data bits; unused upper bits must be zero
  function automatic logic parity_calc(input logic [8:0] data, input int mode);
    logic p;
    p = 1'b0;
    if (mode == PAR_EVEN) p = ^data;
    else if (mode == PAR_ODD) p = ~(^data);
    return p;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - show-ahead synchronous FIFO with full/empty/count
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_wr_en,
  input  logic [WIDTH-1:0]               i_wr_data,
  input  logic                           i_rd_en,
  output logic [WIDTH-1:0]               o_rd_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_hold;
  logic             w_rd;
  logic             w_wr;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot
  assign w_rd = i_rd_en & ~o_empty;
  assign w_wr = i_wr_en & (~o_full | w_rd);

  // While empty, keep presenting the last entry that was popped
  assign o_rd_data = o_empty ? r_hold : r_mem[r_rd_ptr];

  // Storage array, written at the tail pointer
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers, occupancy and the held head value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a show-ahead receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 2,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                              UART_clk,
  input  logic                              rst_n,
  input  logic                              rx,
  input  logic                              rd_en,
  input  logic                              clr_oe,
  output logic [DATA_BITS+2:0]              rd_data,
  output logic                              rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              rx_done_tick,
  output logic                              OE,
  output logic                              rx_busy
);

  localparam int              TW        = $clog2(OVERSAMPLE);
  localparam int              EW        = DATA_BITS + 3;
  localparam logic [TW-1:0]   T_MID     = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0]   T_END     = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [2:0]           r_state;
  logic [TW-1:0]        r_cnt;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit;
  logic                 r_fe;
  logic                 r_done_tick;
  logic                 r_oe;

  logic                 w_fall;
  logic                 w_end;
  logic                 w_done;
  logic                 w_fe;
  logic                 w_pe;
  logic                 w_be;
  logic [8:0]           w_par_in;
  logic [EW-1:0]        w_entry;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_ovr;

  assign w_fall = r_rx_prev & ~r_rx_s;
  assign w_end  = (r_cnt == T_END);
  assign w_done = (r_state == ST_STOP) && w_end && (r_stop_idx == STOP_LAST);

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  // Frame FSM: start validation at half a bit, then one sample per bit centre
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_par_bit  <= 1'b0;
      r_fe       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == T_MID) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_state    <= ST_DATA;
              r_bit_idx  <= '0;
              r_stop_idx <= 1'b0;
              r_par_bit  <= 1'b0;
              r_fe       <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_end) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_idx == BIT_LAST) begin
              r_state <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_end) begin
            r_par_bit <= r_rx_s;
            r_state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_end) begin
            if (!r_rx_s) r_fe <= 1'b1;
            if (r_stop_idx == STOP_LAST) r_state <= ST_IDLE;
            else r_stop_idx <= r_stop_idx + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Assemble the completed entry; the final stop sample is folded in combinationally
  always_comb begin
    w_par_in                   = '0;
    w_par_in[DATA_BITS-1:0]    = r_shift;
    w_fe                       = r_fe | ~r_rx_s;
    w_pe                       = (PARITY_MODE != PAR_NONE) &&
                                 (r_par_bit != parity_calc(w_par_in, PARITY_MODE));
    w_be                       = (r_shift == '0) && w_fe &&
                                 ((PARITY_MODE == PAR_NONE) || !r_par_bit);
    w_entry                    = '0;
    w_entry[DATA_BITS-1:0]     = r_shift;
    w_entry[DATA_BITS+FLAG_FE] = w_fe;
    w_entry[DATA_BITS+FLAG_PE] = w_pe;
    w_entry[DATA_BITS+FLAG_BE] = w_be;
  end

  // A frame is lost only if the FIFO is full and nothing is popped that cycle
  assign w_ovr = w_done & w_full & ~rd_en;

  // Completion pulse and sticky overrun (set has priority over clear)
  always_ff @(posedge UART_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_tick <= 1'b0;
      r_oe        <= 1'b0;
    end else begin
      r_done_tick <= w_done;
      if (w_ovr) r_oe <= 1'b1;
      else if (clr_oe) r_oe <= 1'b0;
    end
  end

  uart_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (UART_clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (w_done),
    .i_wr_data (w_entry),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fifo_count)
  );

  assign rd_valid     = ~w_empty;
  assign rx_done_tick = r_done_tick;
  assign OE           = r_oe;
  assign rx_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed bench for the UART receiver and its FIFO
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  logic        clk;
  logic        rst_n;

  logic        rx_a, rd_en_a, clr_oe_a;
  logic [10:0] rd_data_a;
  logic        rd_valid_a, tick_a, oe_a, busy_a;
  logic [3:0]  count_a;

  logic        rx_b, rd_en_b, clr_oe_b;
  logic [9:0]  rd_data_b;
  logic        rd_valid_b, tick_b, oe_b, busy_b;
  logic [3:0]  count_b;

  int total = 0;
  int bad   = 0;
  int n_tick_a = 0;
  int n_tick_b = 0;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs [8];

  uart_rx_fifo #(
    .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(8)
  ) u_dut_a (
    .UART_clk(clk), .rst_n(rst_n), .rx(rx_a), .rd_en(rd_en_a), .clr_oe(clr_oe_a),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .fifo_count(count_a),
    .rx_done_tick(tick_a), .OE(oe_a), .rx_busy(busy_a)
  );

  uart_rx_fifo #(
    .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .OVERSAMPLE(16), .FIFO_DEPTH(8)
  ) u_dut_b (
    .UART_clk(clk), .rst_n(rst_n), .rx(rx_b), .rd_en(rd_en_b), .clr_oe(clr_oe_b),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .fifo_count(count_b),
    .rx_done_tick(tick_b), .OE(oe_b), .rx_busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (tick_a) n_tick_a++;
  always @(negedge clk) if (tick_b) n_tick_b++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_a = f[i];
      repeat (16) tick();
    end
    rx_a = 1'b1;
    repeat (16) tick();
  endtask

  task automatic send_b(input logic [6:0] d, input logic s1, input logic s2);
    logic [9:0] f;
    f = {s2, s1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_b = f[i];
      repeat (16) tick();
    end
    rx_b = 1'b1;
    repeat (16) tick();
  endtask

  task automatic pop_a();
    rd_en_a = 1'b1;
    tick();
    rd_en_a = 1'b0;
  endtask

  task automatic pop_b();
    rd_en_b = 1'b1;
    tick();
    rd_en_b = 1'b0;
  endtask

  initial begin
    int t0;
    logic [7:0] d;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 11'h055};
    vecs[1] = '{8'hAA, 1'b0, 1'b1, 11'h2AA};
    vecs[2] = '{8'hAA, 1'b1, 1'b0, 11'h1AA};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 11'h100};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 11'h700};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 11'h0FF};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 11'h080};
    vecs[7] = '{8'h80, 1'b1, 1'b1, 11'h280};

    rst_n = 1'b0;
    rx_a = 1'b1; rd_en_a = 1'b0; clr_oe_a = 1'b0;
    rx_b = 1'b1; rd_en_b = 1'b0; clr_oe_b = 1'b0;
    repeat (4) tick();
    check("rst_valid_a", rd_valid_a, 0);
    check("rst_count_a", count_a, 0);
    check("rst_data_a", rd_data_a, 0);
    check("rst_oe_a", oe_a, 0);
    check("rst_tick_a", tick_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_valid_b", rd_valid_b, 0);
    rst_n = 1'b1;
    repeat (20) tick();
    check("idle_busy_a", busy_a, 0);

    // Table: one frame, check entry, pop, check empty with held value
    for (int v = 0; v < 8; v++) begin
      t0 = n_tick_a;
      send_a(vecs[v].data, vecs[v].par, vecs[v].stop);
      check($sformatf("v%0d_ticks", v), n_tick_a - t0, 1);
      check($sformatf("v%0d_count", v), count_a, 1);
      check($sformatf("v%0d_valid", v), rd_valid_a, 1);
      check($sformatf("v%0d_data", v), rd_data_a, vecs[v].exp);
      pop_a();
      check($sformatf("v%0d_valid_after_pop", v), rd_valid_a, 0);
      check($sformatf("v%0d_hold", v), rd_data_a, vecs[v].exp);
    end

    // False start: 6 low cycles
    t0 = n_tick_a;
    rx_a = 1'b0;
    repeat (6) tick();
    rx_a = 1'b1;
    check("false_start_busy", busy_a, 1);
    repeat (10) tick();
    check("false_start_idle", busy_a, 0);
    repeat (32) tick();
    check("false_start_ticks", n_tick_a - t0, 0);
    check("false_start_empty", rd_valid_a, 0);

    // Break: line low for 12 bit times
    t0 = n_tick_a;
    rx_a = 1'b0;
    repeat (192) tick();
    check("break_busy_low", busy_a, 0);
    rx_a = 1'b1;
    repeat (48) tick();
    check("break_ticks", n_tick_a - t0, 1);
    check("break_count", count_a, 1);
    check("break_data", rd_data_a, 11'h700);
    pop_a();

    // Overrun: nine frames into an eight-entry FIFO
    t0 = n_tick_a;
    for (int i = 1; i <= 9; i++) begin
      d = 8'(i);
      send_a(d, ~(^d), 1'b1);
    end
    check("ovr_ticks", n_tick_a - t0, 9);
    check("ovr_count", count_a, 8);
    check("ovr_oe", oe_a, 1);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovr_pop%0d", i), rd_data_a, i);
      pop_a();
    end
    check("ovr_empty", rd_valid_a, 0);
    check("ovr_hold", rd_data_a, 8);
    check("ovr_oe_sticky", oe_a, 1);
    clr_oe_a = 1'b1;
    tick();
    clr_oe_a = 1'b0;
    check("ovr_oe_cleared", oe_a, 0);

    // Seven data bits, no parity, two stop bits; second stop bit low
    t0 = n_tick_b;
    send_b(7'h3F, 1'b1, 1'b0);
    check("b_ticks", n_tick_b - t0, 1);
    check("b_data_fe", rd_data_b, 10'h0BF);
    pop_b();
    check("b_empty", rd_valid_b, 0);

    // Fill, then push while full with a pop in the completion cycle
    for (int i = 0; i < 8; i++) send_b(7'(8'h10 + i), 1'b1, 1'b1);
    check("b_full_count", count_b, 8);
    t0 = n_tick_b;
    tick();
    fork
      send_b(7'h55, 1'b1, 1'b1);
      begin
        repeat (154) tick();
        rd_en_b = 1'b1;
        tick();
        rd_en_b = 1'b0;
      end
    join
    check("b_pushpop_tick", n_tick_b - t0, 1);
    check("b_pushpop_count", count_b, 8);
    check("b_pushpop_oe", oe_b, 0);
    check("b_pushpop_head", rd_data_b, 10'h011);
    repeat (7) pop_b();
    check("b_pushpop_tail", rd_data_b, 10'h055);
    pop_b();
    check("b_drained", count_b, 0);

    // Reset mid-frame discards the frame and the FIFO contents
    send_a(8'h5A, ~(^8'h5A), 1'b1);
    check("mid_rst_pre_count", count_a, 1);
    rx_a = 1'b0;
    repeat (40) tick();
    check("mid_rst_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy_cleared", busy_a, 0);
    check("mid_rst_count", count_a, 0);
    rx_a = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("mid_rst_valid", rd_valid_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
